// File: rtl/reg_display_reader.sv
// Reads one register through the bank's read port and converts it to four
// 7-segment digit codes using a one-shift-per-clock double-dabble.
module reg_display_reader #(
    parameter bit         SIGNED     = 1'b0,
    parameter logic [6:0] BLANK_CODE = 7'd126,
    parameter logic [6:0] DASH_CODE  = 7'd127
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  RegSelect,
    input  logic [31:0] ReadData,
    output logic [4:0]  ReadRegister,
    output logic        busy,
    output logic        done,
    output logic [6:0]  Digit3,
    output logic [6:0]  Digit2,
    output logic [6:0]  Digit1,
    output logic [6:0]  Digit0
);

    typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, CHECK, CONVERT, BLANK, DONE} state_t;

    state_t      state;
    logic [31:0] val_q;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [3:0]  iter;
    logic        neg;

    logic        is_neg;
    logic [31:0] mag;
    logic        ovf;
    logic [15:0] bcd_adj;
    logic        z3, z2, z1;

    assign is_neg = SIGNED && val_q[31];
    assign mag    = is_neg ? (~val_q + 32'd1) : val_q;
    // The most negative value negates to itself, so it is caught explicitly.
    assign ovf    = SIGNED ? ((mag > 32'd999) || (val_q == 32'h8000_0000))
                           : (mag > 32'd9999);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign z3 = (bcd[15:12] == 4'd0);
    assign z2 = (bcd[11:8]  == 4'd0);
    assign z1 = (bcd[7:4]   == 4'd0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            ReadRegister <= 5'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            Digit3       <= BLANK_CODE;
            Digit2       <= BLANK_CODE;
            Digit1       <= BLANK_CODE;
            Digit0       <= BLANK_CODE;
            val_q        <= 32'd0;
            bin          <= 14'd0;
            bcd          <= 16'd0;
            iter         <= 4'd0;
            neg          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ReadRegister <= RegSelect;
                        busy         <= 1'b1;
                        state        <= ADDR;
                    end
                end
                ADDR:    state <= CAPTURE;
                CAPTURE: begin
                    val_q <= ReadData;
                    state <= CHECK;
                end
                CHECK: begin
                    neg <= is_neg;
                    if (ovf) begin
                        Digit3 <= DASH_CODE;
                        Digit2 <= DASH_CODE;
                        Digit1 <= DASH_CODE;
                        Digit0 <= DASH_CODE;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        bin   <= mag[13:0];
                        bcd   <= 16'd0;
                        iter  <= 4'd0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    iter       <= iter + 4'd1;
                    if (iter == 4'd13)
                        state <= BLANK;
                end
                BLANK: begin
                    // Negative values are at most 999, so Digit3 is free for the dash.
                    Digit3 <= neg ? DASH_CODE : (z3 ? BLANK_CODE : {3'd0, bcd[15:12]});
                    Digit2 <= (z3 && z2)       ? BLANK_CODE : {3'd0, bcd[11:8]};
                    Digit1 <= (z3 && z2 && z1) ? BLANK_CODE : {3'd0, bcd[7:4]};
                    Digit0 <= {3'd0, bcd[3:0]};
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
